score_display_scanner: RTL
==========================

Name: score_display_scanner

Overview:
- Sits directly upstream of the 7-segment decoder; drives its digit select, nibble and dot inputs so the score is shown across all four digits.
- Takes the binary score from the score counter and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Tracks a high score and time-multiplexes the digits at a fixed scan rate, with leading-zero blanking.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is held (2 kHz per digit at 100 MHz); legal range 2..2^20.

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
SCORE_IN  input  8  current binary score, 0..255
SHOW_HIGH  input  1  1 = display the high score, 0 = display the current score
SEG_SELECT_OUT  output  2  digit index to decoder (0 = rightmost)
BIN_OUT  output  4  BCD nibble for the selected digit
DOT_OUT  output  1  decimal point for the selected digit
BLANK_OUT  output  1  1 = selected digit must be dark; top level gates the anodes with it
BUSY  output  1  1 while a conversion is in progress

Behaviour:
- Interface: one clock, CLK. Reset RESET is asynchronous and active-high.
- Reset values:
  - SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, BLANK_OUT=1, BUSY=0.
  - High score 0, latched source 0, display BCD 000, prescaler 0, FSM IDLE.
- Reset asserted mid-conversion aborts the conversion and restores all reset values.
- High score register:
  - Each edge: if SCORE_IN > high then high <= SCORE_IN (unsigned compare).
  - Cleared only by RESET.
- Source select: src = SHOW_HIGH ? high : SCORE_IN (combinational).
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: if src != latched_src, latch src into latched_src and the shift register, clear the BCD accumulator, set BUSY=1, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: 8 cycles, counted by a 3-bit counter. Each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1. After the 8th shift, go to COMMIT.
  - COMMIT: copy the accumulator to the display BCD register (hundreds/tens/ones, 10 bits). Set BUSY=0, go to IDLE.
- Timing:
  - Change sampled at edge k -> display register updated at edge k+9.
  - BUSY is high from edge k to edge k+9.
  - The display register is never partially updated.
- src changes during SHIFT/COMMIT are ignored. They are re-detected in IDLE, because the compare is against latched_src.
  - Back-to-back changes therefore produce back-to-back conversions, each 10 cycles including the IDLE cycle.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the terminal count, digit index increments 0->1->2->3->0.
- Digit outputs are all registered and update together on the edge after the digit index changes:
  - Digit 0: BIN_OUT = ones; never blanked; DOT_OUT = SHOW_HIGH.
  - Digit 1: BIN_OUT = tens; BLANK_OUT = (hundreds==0 && tens==0); DOT_OUT = 0.
  - Digit 2: BIN_OUT = hundreds; BLANK_OUT = (hundreds==0); DOT_OUT = 0.
  - Digit 3: BIN_OUT = 0, BLANK_OUT = 1, DOT_OUT = 0.
- Scan and conversion are independent. A COMMIT between scan steps is visible at the next scan step.
- Outputs never show a digit index paired with stale data from another digit.

Decomposition:
- Shared package (snake_display_pkg):
  - FSM state encoding: IDLE, SHIFT, COMMIT.
  - Digit index constants DIG_ONES=0, DIG_TENS=1, DIG_HUNDS=2, DIG_SPARE=3.
  - BCD_WIDTH=10 and SHIFT_CYCLES=8.
- One sub-module, bin2bcd_serial:
  - Owns the FSM, the shift/add-3 datapath and the BUSY/COMMIT handshake.
  - The top of this block keeps the high-score register, prescaler, digit mux and blanking.

Test Plan:
- Reset, then SCAN_DIV=4 with SCORE_IN=0: cycle digits 0..3 with 4 cycles per digit. Expect digit 0 showing BIN_OUT=0, BLANK=0; digits 1, 2, 3 BLANK=1; DOT_OUT=0 everywhere.
- SCORE_IN 0 -> 137 at edge k: BUSY high k..k+9. From the next scan step: digit0=7, digit1=3, digit2=1, none blanked on digits 0..2.
- SCORE_IN=9 then 10 then 255 as 10-cycle steps: displays 9 (tens and hundreds blank), then 10 (hundreds blank), then 255. Check the double-dabble boundary nibbles.
- SCORE_IN 200 -> 50, then SHOW_HIGH=1: live value shows 50. After SHOW_HIGH=1, display goes to 200 within 10 cycles, with DOT_OUT=1 on digit 0 only.
- SCORE_IN changes 12 -> 34 three cycles into a conversion: first COMMIT shows 12. A second conversion starts in IDLE and COMMITs 34 within the following 10 cycles.
- RESET pulse mid-SHIFT while showing high score 200: all outputs return to reset values immediately (asynchronous). After release, high score=0 and the display shows 0.

Source files
------------

// File: rtl/score_display_scanner_pkg.sv
// Shared types and constants for the score display scanner and its BCD converter.
package snake_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    localparam logic [1:0] DIG_ONES  = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;
    localparam logic [1:0] DIG_SPARE = 2'd3;

    localparam int BCD_WIDTH    = 10;
    localparam int SHIFT_CYCLES = 8;

    // Hundreds never exceeds 2 for an 8-bit source, so only ones and tens need the +3 step.
    function automatic logic [BCD_WIDTH-1:0] add3_bcd(input logic [BCD_WIDTH-1:0] b);
        logic [BCD_WIDTH-1:0] r;
        r = b;
        if (b[3:0] >= 4'd5) r[3:0] = b[3:0] + 4'd3;
        if (b[7:4] >= 4'd5) r[7:4] = b[7:4] + 4'd3;
        return r;
    endfunction

endpackage

// File: rtl/score_display_scanner_if.sv
// Score input and digit-drive bundle between the score logic and the 7-segment decoder.
// Handshake: no valid/ready; BUSY is high while a conversion runs and drops on the edge the display register is committed.
interface score_display_scanner_if;
    import snake_display_pkg::*;

    logic [7:0]  SCORE_IN;
    logic        SHOW_HIGH;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  BIN_OUT;
    logic        DOT_OUT;
    logic        BLANK_OUT;
    logic        BUSY;
    conv_state_t fsm_state;

    modport master (
        output SCORE_IN, SHOW_HIGH,
        input  SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, BUSY, fsm_state
    );

    modport slave (
        input  SCORE_IN, SHOW_HIGH,
        output SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, BUSY, fsm_state
    );

endinterface

// File: rtl/score_display_scanner_bin2bcd_serial.sv
// Sequential double-dabble converter: detects a source change, shifts for eight cycles,
// then commits the whole BCD result to the display register in one edge.
module bin2bcd_serial
    import snake_display_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           src,
    output logic                 busy,
    output logic [BCD_WIDTH-1:0] disp,
    output conv_state_t          state_dbg
);

    conv_state_t          state, state_next;
    logic [7:0]           lat, lat_next;
    logic [7:0]           shreg, shreg_next;
    logic [BCD_WIDTH-1:0] acc, acc_next;
    logic [BCD_WIDTH-1:0] disp_next;
    logic [2:0]           cnt, cnt_next;
    logic [BCD_WIDTH+7:0] shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lat   <= '0;
            shreg <= '0;
            acc   <= '0;
            disp  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            lat   <= lat_next;
            shreg <= shreg_next;
            acc   <= acc_next;
            disp  <= disp_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        lat_next   = lat;
        shreg_next = shreg;
        acc_next   = acc;
        disp_next  = disp;
        cnt_next   = cnt;
        shifted    = '0;
        case (state)
            IDLE: begin
                // Compare against the latched copy so changes seen while busy are picked up here.
                if (src != lat) begin
                    lat_next   = src;
                    shreg_next = src;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shifted    = {add3_bcd(acc), shreg} << 1;
                acc_next   = shifted[BCD_WIDTH+7:8];
                shreg_next = shifted[7:0];
                cnt_next   = cnt + 3'd1;
                if (cnt == 3'(SHIFT_CYCLES - 1)) state_next = COMMIT;
            end
            COMMIT: begin
                disp_next  = acc;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: rtl/score_display_scanner.sv
// Score display front end: high-score tracking, BCD conversion and 4-digit scan with
// leading-zero blanking, feeding the 7-segment decoder.
module score_display_scanner
    import snake_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic                    CLK,
    input logic                    RESET,
    score_display_scanner_if.slave bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [7:0]           high;
    logic [7:0]           src;
    logic [BCD_WIDTH-1:0] disp;
    logic [PW-1:0]        pre;
    logic [1:0]           dig;
    logic [3:0]           dig_bin;
    logic                 dig_blank;
    logic                 dig_dot;
    logic [3:0]           ones, tens, hunds;

    assign src   = bus.SHOW_HIGH ? high : bus.SCORE_IN;
    assign ones  = disp[3:0];
    assign tens  = disp[7:4];
    assign hunds = {2'b00, disp[9:8]};

    bin2bcd_serial u_conv (
        .clk       (CLK),
        .rst       (RESET),
        .src       (src),
        .busy      (bus.BUSY),
        .disp      (disp),
        .state_dbg (bus.fsm_state)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            high <= '0;
            pre  <= '0;
            dig  <= DIG_ONES;
        end else begin
            if (bus.SCORE_IN > high) high <= bus.SCORE_IN;
            if (pre == PW'(SCAN_DIV - 1)) begin
                pre <= '0;
                dig <= dig + 2'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    always_comb begin
        dig_bin   = 4'd0;
        dig_blank = 1'b1;
        dig_dot   = 1'b0;
        case (dig)
            DIG_ONES: begin
                dig_bin   = ones;
                dig_blank = 1'b0;
                dig_dot   = bus.SHOW_HIGH;
            end
            DIG_TENS: begin
                dig_bin   = tens;
                dig_blank = (hunds == 4'd0) && (tens == 4'd0);
            end
            DIG_HUNDS: begin
                dig_bin   = hunds;
                dig_blank = (hunds == 4'd0);
            end
            default: ;
        endcase
    end

    // Index and digit data are registered together so they can never disagree.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.SEG_SELECT_OUT <= DIG_ONES;
            bus.BIN_OUT        <= 4'd0;
            bus.DOT_OUT        <= 1'b0;
            bus.BLANK_OUT      <= 1'b1;
        end else begin
            bus.SEG_SELECT_OUT <= dig;
            bus.BIN_OUT        <= dig_bin;
            bus.DOT_OUT        <= dig_dot;
            bus.BLANK_OUT      <= dig_blank;
        end
    end

endmodule
